// File: rtl/mem_stage_sbuf_if.sv
// Bundles for the memory stage.
//
// mem_req_if : pipeline side of the stage.
//   req_ren/req_wen/req_addr/req_wdata/drain  pipeline -> stage
//   stall/rdata/rdata_valid/empty             stage -> pipeline
//   master = pipeline, slave = memory stage
//
// dmem_if : data-cache port.
//   dmemREN/dmemWEN/dmemaddr/dmemstore        stage -> cache
//   dhit/dmemload                             cache -> stage
//   master = memory stage, slave = cache

interface mem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_ren;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              drain;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              empty;

    modport master (
        output req_ren, req_wen, req_addr, req_wdata, drain,
        input  stall, rdata, rdata_valid, empty
    );

    modport slave (
        input  req_ren, req_wen, req_addr, req_wdata, drain,
        output stall, rdata, rdata_valid, empty
    );
endinterface

interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_stage_sbuf.sv
// Memory stage with a posted store buffer.
//
// Stores retire into a DEPTH-entry circular FIFO and are written to the
// data cache in the background. Loads forward from the youngest matching
// buffered store, otherwise they read the cache (and may bypass older,
// non-matching buffered stores).
//
// Ports:
//   CLK, nRST  clock, asynchronous active-low reset
//   req        mem_req_if.slave : pipeline requests, stall, load result
//   dmem       dmem_if.master   : cache strobes/address/data, dhit/dmemload
//   dbg_state  current FSM state (IDLE/LOAD/DRAIN) for observation
//
// Handshake: a request (req_ren or req_wen) is accepted on the rising edge
// of a cycle in which stall=0; while stall=1 the pipeline holds the request
// unchanged. rdata is valid only in the cycle rdata_valid=1. A cache access
// is in flight while dmemREN or dmemWEN is high and completes in the cycle
// dhit=1; its strobe, address and data never change before that cycle.

module mem_stage_sbuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       CLK,
    input  logic       nRST,
    mem_req_if.slave   req,
    dmem_if.master     dmem,
    output logic [1:0] dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;

    // Buffer storage needs no reset: count_q defines which entries are live.
    logic [ADDR_W-1:0]   buf_addr_q [DEPTH];
    logic [DATA_W-1:0]   buf_data_q [DEPTH];

    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;
    logic                st_accept;
    logic                ld_fwd;
    logic                ld_miss;
    logic                ld_done;
    logic                drain_done;

    // Youngest-match search: walk from head towards tail, later (younger)
    // matches overwrite earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (buf_addr_q[head_q + PTR_W'(i)] == req.req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[head_q + PTR_W'(i)];
            end
        end
    end

    // Full-ness is judged on the registered count, so a slot freed by a
    // drain dhit is only usable from the following cycle.
    assign st_accept  = req.req_wen && (count_q < CNT_W'(DEPTH)) && !req.drain;
    assign ld_fwd     = req.req_ren && fwd_hit;
    assign ld_miss    = req.req_ren && !fwd_hit;
    assign ld_done    = (state_q == LOAD) && dmem.dhit;
    assign drain_done = (state_q == DRAIN) && dmem.dhit;

    assign req.stall  = (req.req_wen && !st_accept) || (ld_miss && !ld_done);

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        ld_addr_d     = ld_addr_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A waiting load miss wins over starting the next drain.
                if (ld_miss) begin
                    state_d   = LOAD;
                    ld_addr_d = req.req_addr;
                end else if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            LOAD: begin
                if (dmem.dhit) begin
                    state_d       = IDLE;
                    rdata_d       = dmem.dmemload;
                    rdata_valid_d = 1'b1;
                end
            end
            DRAIN: begin
                if (dmem.dhit) begin
                    state_d = IDLE;
                    head_d  = head_q + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld_fwd) begin
            rdata_d       = fwd_data;
            rdata_valid_d = 1'b1;
        end

        if (st_accept) begin
            tail_d = tail_q + PTR_W'(1);
        end

        unique case ({st_accept, drain_done})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ld_addr_q     <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ld_addr_q     <= ld_addr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (st_accept) begin
            buf_addr_q[tail_q] <= req.req_addr;
            buf_data_q[tail_q] <= req.req_wdata;
        end
    end

    // Cache port depends only on registered state and buffer contents.
    always_comb begin
        dmem.dmemREN   = 1'b0;
        dmem.dmemWEN   = 1'b0;
        dmem.dmemaddr  = '0;
        dmem.dmemstore = '0;
        unique case (state_q)
            LOAD: begin
                dmem.dmemREN  = 1'b1;
                dmem.dmemaddr = ld_addr_q;
            end
            DRAIN: begin
                dmem.dmemWEN   = 1'b1;
                dmem.dmemaddr  = buf_addr_q[head_q];
                dmem.dmemstore = buf_data_q[head_q];
            end
            default: ;
        endcase
    end

    assign req.rdata       = rdata_q;
    assign req.rdata_valid = rdata_valid_q;
    assign req.empty       = (count_q == '0) && (state_q == IDLE);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_stage_sbuf.sv
module tb_mem_stage_sbuf;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    // ---------------- clock / reset ----------------
    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_req_if #(.ADDR_W(AW), .DATA_W(DW)) req_if ();
    dmem_if    #(.ADDR_W(AW), .DATA_W(DW)) dm_if ();
    logic [1:0] dbg_state;

    mem_stage_sbuf #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (req_if),
        .dmem      (dm_if),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    // arch_mem: memory as the program sees it (every accepted store applied).
    // cache_mem: what the cache actually holds (writes applied on dhit).
    logic [DW-1:0]    arch_mem  [logic [AW-1:0]];
    logic [DW-1:0]    cache_mem [logic [AW-1:0]];
    logic [DW-1:0]    exp_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];
    int total = 0;
    int bad   = 0;
    int dhit_mode = 1;  // 0 random, 1 never, 2 whenever an access is open

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    function automatic logic [DW-1:0] cache_rd(input logic [AW-1:0] a);
        return cache_mem.exists(a) ? cache_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] arch_rd(input logic [AW-1:0] a);
        return arch_mem.exists(a) ? arch_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- cache responder ----------------
    logic          prev_pend = 1'b0;
    logic [1:0]    prev_kind;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic          strobe;

    initial begin
        dm_if.dhit     = 1'b0;
        dm_if.dmemload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (!nRST) begin
                prev_pend = 1'b0;
            end else if (prev_pend) begin
                // An open access must stay exactly as it was until dhit.
                check("access_held_kind", {dm_if.dmemREN, dm_if.dmemWEN}, prev_kind);
                check("access_held_addr", dm_if.dmemaddr, prev_addr);
                if (prev_kind == 2'b01) check("access_held_data", dm_if.dmemstore, prev_data);
            end
            strobe = dm_if.dmemREN || dm_if.dmemWEN;
            case (dhit_mode)
                0:       dm_if.dhit = strobe && ($urandom_range(0, 2) == 0);
                2:       dm_if.dhit = strobe;
                default: dm_if.dhit = 1'b0;
            endcase
            dm_if.dmemload = dm_if.dmemREN ? cache_rd(dm_if.dmemaddr) : $urandom();
            prev_pend = nRST && strobe && !dm_if.dhit;
            prev_kind = {dm_if.dmemREN, dm_if.dmemWEN};
            prev_addr = dm_if.dmemaddr;
            prev_data = dm_if.dmemstore;
        end
    end

    // ---------------- monitor ----------------
    logic [AW+DW-1:0] wr_e;
    logic [DW-1:0]    rd_e;

    initial begin
        forever begin
            @(negedge CLK);
            if (nRST) begin
                if (dm_if.dhit && dm_if.dmemWEN) begin
                    if (exp_wr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got addr %0h data %0h want none",
                                 dm_if.dmemaddr, dm_if.dmemstore);
                    end else begin
                        wr_e = exp_wr_q.pop_front();
                        check("wr_addr", dm_if.dmemaddr, wr_e[AW+DW-1:DW]);
                        check("wr_data", dm_if.dmemstore, wr_e[DW-1:0]);
                    end
                    cache_mem[dm_if.dmemaddr] = dm_if.dmemstore;
                end
                if (req_if.rdata_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rdata: got %0h want none", req_if.rdata);
                    end else begin
                        rd_e = exp_q.pop_front();
                        check("rdata", req_if.rdata, rd_e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (called and return at posedge+1) ----------------
    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, output int stalls);
        req_if.req_wen   = 1'b1;
        req_if.req_addr  = a;
        req_if.req_wdata = d;
        stalls = 0;
        forever begin
            @(negedge CLK);
            if (!req_if.stall) begin
                arch_mem[a] = d;
                exp_wr_q.push_back({a, d});
                break;
            end
            stalls++;
            if (stalls > 300) begin
                total++;
                bad++;
                $display("FAIL store_timeout: got stall after %0d cycles want accept", stalls);
                break;
            end
        end
        @(posedge CLK);
        #1;
        req_if.req_wen = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, output int stalls);
        exp_q.push_back(arch_rd(a));
        req_if.req_ren  = 1'b1;
        req_if.req_addr = a;
        stalls = 0;
        forever begin
            @(negedge CLK);
            if (!req_if.stall) break;
            stalls++;
            if (stalls > 300) begin
                total++;
                bad++;
                $display("FAIL load_timeout: got stall after %0d cycles want accept", stalls);
                break;
            end
        end
        @(posedge CLK);
        #1;
        req_if.req_ren = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!req_if.empty && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("empty_reached", req_if.empty, 1'b1);
        @(posedge CLK);
        #1;
    endtask

    task automatic flush_all();
        req_if.drain = 1'b1;
        dhit_mode    = 0;
        wait_empty();
        req_if.drain = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int st;
    int ld;
    logic [AW-1:0] ra;

    initial begin
        req_if.req_ren   = 1'b0;
        req_if.req_wen   = 1'b0;
        req_if.req_addr  = '0;
        req_if.req_wdata = '0;
        req_if.drain     = 1'b0;

        #3;
        check("rst_stall", req_if.stall, 1'b0);
        check("rst_empty", req_if.empty, 1'b1);
        check("rst_ren", dm_if.dmemREN, 1'b0);
        check("rst_wen", dm_if.dmemWEN, 1'b0);
        check("rst_rvalid", req_if.rdata_valid, 1'b0);
        check("rst_rdata", req_if.rdata, 32'h0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Forwarding from the youngest of two matching stores.
        dhit_mode = 1;
        do_store(32'h100, 32'hAAAA, st);
        check("store1_no_stall", st, 0);
        do_store(32'h104, 32'hBBBB, st);
        do_store(32'h100, 32'hCCCC, st);
        do_load(32'h100, ld);
        check("fwd_no_stall", ld, 0);
        @(negedge CLK);
        check("fwd_no_ren", dm_if.dmemREN, 1'b0);
        check("fwd_rvalid", req_if.rdata_valid, 1'b1);
        @(posedge CLK);
        #1;

        // Full buffer: 4th store fits, 5th waits for a single dhit.
        do_store(32'h108, 32'hDDDD, st);
        check("store4_no_stall", st, 0);
        fork
            do_store(32'h10C, 32'hEEEE, st);
            begin
                @(negedge CLK);
                check("full_stall", req_if.stall, 1'b1);
                dhit_mode = 2;
                @(negedge CLK);
                check("full_stall_on_dhit", req_if.stall, 1'b1);
                dhit_mode = 1;
            end
        join
        check("full_accept_after", st, 2);
        req_if.req_wen   = 1'b1;
        req_if.req_addr  = 32'h110;
        req_if.req_wdata = 32'h1111;
        @(negedge CLK);
        check("full_again_stall", req_if.stall, 1'b1);
        @(posedge CLK);
        #1;
        req_if.req_wen = 1'b0;
        flush_all();

        // Load miss arriving during an outstanding drain, then winning IDLE.
        dhit_mode = 1;
        do_store(32'h300, 32'h3030, st);
        do_store(32'h304, 32'h3434, st);
        fork
            do_load(32'h208, ld);
            begin
                @(negedge CLK);
                check("dr_wen_held", dm_if.dmemWEN, 1'b1);
                check("dr_no_ren", dm_if.dmemREN, 1'b0);
                check("dr_addr", dm_if.dmemaddr, 32'h300);
                check("dr_ld_stall", req_if.stall, 1'b1);
                dhit_mode = 2;
                @(negedge CLK);
                check("dr_ld_stall_dhit", req_if.stall, 1'b1);
                dhit_mode = 1;
                @(negedge CLK);
                check("gap_no_strobe", {dm_if.dmemREN, dm_if.dmemWEN}, 2'b00);
                @(negedge CLK);
                check("miss_wins_ren", dm_if.dmemREN, 1'b1);
                check("miss_wins_wen", dm_if.dmemWEN, 1'b0);
                check("miss_addr", dm_if.dmemaddr, 32'h208);
                dhit_mode = 2;
                @(negedge CLK);
                check("miss_accept", req_if.stall, 1'b0);
                dhit_mode = 1;
            end
        join
        check("miss_stall_cycles", ld, 4);
        flush_all();

        // drain=1: stores blocked, buffer written out in order.
        dhit_mode = 1;
        do_store(32'h400, 32'h4000, st);
        do_store(32'h404, 32'h4040, st);
        do_store(32'h400, 32'h4444, st);
        req_if.drain     = 1'b1;
        req_if.req_wen   = 1'b1;
        req_if.req_addr  = 32'h408;
        req_if.req_wdata = 32'h4848;
        @(negedge CLK);
        check("drain_store_stall", req_if.stall, 1'b1);
        @(posedge CLK);
        #1;
        req_if.req_wen = 1'b0;
        dhit_mode = 0;
        wait_empty();
        check("drain_all_written", exp_wr_q.size(), 0);
        req_if.req_wen = 1'b1;
        @(negedge CLK);
        check("drain_still_stall", req_if.stall, 1'b1);
        req_if.drain = 1'b0;
        #1;
        check("drain_release", req_if.stall, 1'b0);
        @(posedge CLK);
        #1;
        req_if.req_wen = 1'b0;
        arch_mem[32'h408] = 32'h4848;
        exp_wr_q.push_back({32'h408, 32'h4848});
        flush_all();

        // Reset in the middle of a drain discards the buffer.
        dhit_mode = 1;
        do_store(32'h500, 32'h5000, st);
        do_store(32'h504, 32'h5050, st);
        do_store(32'h508, 32'h5858, st);
        @(negedge CLK);
        check("pre_rst_wen", dm_if.dmemWEN, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        check("mid_rst_wen", dm_if.dmemWEN, 1'b0);
        check("mid_rst_ren", dm_if.dmemREN, 1'b0);
        check("mid_rst_empty", req_if.empty, 1'b1);
        check("mid_rst_stall", req_if.stall, 1'b0);
        check("mid_rst_rdata", req_if.rdata, 32'h0);
        exp_wr_q.delete();
        arch_mem = cache_mem;
        dhit_mode = 0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (10) @(negedge CLK);
        check("post_rst_empty", req_if.empty, 1'b1);
        @(posedge CLK);
        #1;

        // Randomized traffic against the architectural memory model.
        dhit_mode = 0;
        for (int i = 0; i < 400; i++) begin
            ra = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    if (!req_if.drain) do_store(ra, $urandom(), st);
                end
                4, 5, 6: do_load(ra, ld);
                7: begin
                    req_if.drain = ~req_if.drain;
                    @(posedge CLK);
                    #1;
                end
                default: begin
                    @(posedge CLK);
                    #1;
                end
            endcase
        end
        flush_all();
        repeat (3) @(negedge CLK);
        check("final_wr_queue", exp_wr_q.size(), 0);
        check("final_rd_queue", exp_q.size(), 0);
        check("final_empty", req_if.empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
